// File: rtl/soc_system_seg_display_ctrl.sv
// Seven-segment display back end: PWM brightness, per-digit blink and
// frame-synchronous shadow registers feeding registered active-low HEX outputs.
module soc_system_seg_display_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 500,
  parameter int PWM_BITS     = 4,
  parameter int BLINK_FRAMES = 390
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [7*NUM_DIGITS-1:0] seg_in,
  input  logic [PWM_BITS-1:0]     brightness,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [7*NUM_DIGITS-1:0] hex_out,
  output logic                    frame_tick
);

  localparam int SEG_W = 7 * NUM_DIGITS;
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BL_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [BL_W-1:0]     BL_LAST  = BL_W'(BLINK_FRAMES - 1);
  localparam logic [PWM_BITS-1:0] PWM_MAX  = '1;

  logic [PRE_W-1:0]      pre_cnt_q, pre_cnt_d;
  logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [BL_W-1:0]       bl_cnt_q, bl_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic [SEG_W-1:0]      seg_sh_q, seg_sh_d;
  logic [PWM_BITS-1:0]   bright_sh_q, bright_sh_d;
  logic [NUM_DIGITS-1:0] mask_sh_q, mask_sh_d;
  logic [SEG_W-1:0]      hex_q, hex_d;
  logic                  frame_tick_q, frame_tick_d;

  logic                  step;
  logic                  fb;
  logic                  bl_wrap;
  logic                  pwm_on;
  logic [NUM_DIGITS-1:0] lit;

  assign step    = (pre_cnt_q == PRE_LAST);
  assign fb      = step && (pwm_cnt_q == PWM_MAX);
  assign bl_wrap = fb && (bl_cnt_q == BL_LAST);
  assign pwm_on  = (bright_sh_q == PWM_MAX) || (pwm_cnt_q < bright_sh_q);

  always_comb begin
    pre_cnt_d = step ? '0 : pre_cnt_q + 1'b1;
    pwm_cnt_d = step ? pwm_cnt_q + 1'b1 : pwm_cnt_q;

    bl_cnt_d      = bl_cnt_q;
    blink_phase_d = blink_phase_q;
    if (fb) begin
      bl_cnt_d = bl_wrap ? '0 : bl_cnt_q + 1'b1;
      if (bl_wrap) begin
        blink_phase_d = ~blink_phase_q;
      end
    end

    // Shadows only move on the frame boundary so a frame is never torn
    seg_sh_d     = fb ? seg_in     : seg_sh_q;
    bright_sh_d  = fb ? brightness : bright_sh_q;
    mask_sh_d    = fb ? blink_mask : mask_sh_q;
    frame_tick_d = fb;
  end

  always_comb begin
    lit   = '0;
    hex_d = '1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      lit[d] = pwm_on & ~(mask_sh_q[d] & blink_phase_q);
      hex_d[7*d +: 7] = ~(seg_sh_q[7*d +: 7] & {7{lit[d]}});
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt_q     <= '0;
      pwm_cnt_q     <= '0;
      bl_cnt_q      <= '0;
      blink_phase_q <= 1'b0;
      seg_sh_q      <= '0;
      bright_sh_q   <= '0;
      mask_sh_q     <= '0;
      hex_q         <= '1;
      frame_tick_q  <= 1'b0;
    end else begin
      pre_cnt_q     <= pre_cnt_d;
      pwm_cnt_q     <= pwm_cnt_d;
      bl_cnt_q      <= bl_cnt_d;
      blink_phase_q <= blink_phase_d;
      seg_sh_q      <= seg_sh_d;
      bright_sh_q   <= bright_sh_d;
      mask_sh_q     <= mask_sh_d;
      hex_q         <= hex_d;
      frame_tick_q  <= frame_tick_d;
    end
  end

  assign hex_out    = hex_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_soc_system_seg_display_ctrl.sv
// Bench for the seven-segment display back end: vector table, hand-written
// corner sequences and a time-indexed reference model checked every cycle.
module tb_soc_system_seg_display_ctrl;

  localparam int ND    = 4;
  localparam int PRE   = 2;
  localparam int PB    = 2;
  localparam int BLF   = 2;
  localparam int STEPS = 1 << PB;
  localparam int FRAME = PRE * STEPS;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic [7*ND-1:0] seg_in = '0;
  logic [PB-1:0]   brightness = '0;
  logic [ND-1:0]   blink_mask = '0;
  logic [7*ND-1:0] hex_out;
  logic            frame_tick;

  soc_system_seg_display_ctrl #(
    .NUM_DIGITS(ND), .PRESCALE(PRE), .PWM_BITS(PB), .BLINK_FRAMES(BLF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .seg_in(seg_in), .brightness(brightness),
    .blink_mask(blink_mask), .hex_out(hex_out), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_on   = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: everything is derived from the number of clock edges
  // since reset release and the number of frame boundaries seen so far.
  int              m_k = 0;
  int              m_nfb = 0;
  logic [7*ND-1:0] m_seg = '0;
  int              m_br = 0;
  logic [ND-1:0]   m_mask = '0;
  logic [7*ND-1:0] exp_hex = '1;
  logic            exp_ft = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_k = 0; m_nfb = 0; m_seg = '0; m_br = 0; m_mask = '0;
      exp_hex = '1; exp_ft = 1'b0;
    end else begin
      int  pwm;
      int  phase;
      bit  on;
      pwm   = (m_k / PRE) % STEPS;
      phase = (m_nfb / BLF) % 2;
      on    = (m_br == STEPS - 1) || (pwm < m_br);
      for (int d = 0; d < ND; d++) begin
        if (on && !(m_mask[d] && phase == 1)) exp_hex[7*d +: 7] = ~m_seg[7*d +: 7];
        else exp_hex[7*d +: 7] = 7'h7F;
      end
      exp_ft = ((m_k + 1) % FRAME == 0);
      if (exp_ft) begin
        m_seg = seg_in; m_br = int'(brightness); m_mask = blink_mask;
        m_nfb++;
      end
      m_k++;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_hex", 32'(hex_out), 32'(exp_hex));
      check("model_ft", 32'(frame_tick), 32'(exp_ft));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ft(input string nm);
    int n = 0;
    do begin
      tick();
      n++;
    end while (frame_tick !== 1'b1 && n < FRAME + 4);
    check(nm, 32'(frame_tick), 32'd1);
  endtask

  typedef struct {
    string           name;
    logic [7*ND-1:0] seg;
    logic [PB-1:0]   br;
    logic [7*ND-1:0] exp_hex [STEPS];
  } vec_t;

  vec_t vecs [5];

  initial begin
    int lit0;
    int others_bad;
    int n;

    vecs[0] = '{"b3_digit0", 28'h000007F, 2'd3, '{28'hFFFFF80, 28'hFFFFF80, 28'hFFFFF80, 28'hFFFFF80}};
    vecs[1] = '{"b2_half",   28'hFFFFFFF, 2'd2, '{28'h0000000, 28'h0000000, 28'hFFFFFFF, 28'hFFFFFFF}};
    vecs[2] = '{"b0_dark",   28'hFFFFFFF, 2'd0, '{28'hFFFFFFF, 28'hFFFFFFF, 28'hFFFFFFF, 28'hFFFFFFF}};
    vecs[3] = '{"b1_quarter",28'hFFFFFFF, 2'd1, '{28'h0000000, 28'hFFFFFFF, 28'hFFFFFFF, 28'hFFFFFFF}};
    vecs[4] = '{"b3_digit1", 28'h0003F80, 2'd3, '{28'hFFFC07F, 28'hFFFC07F, 28'hFFFC07F, 28'hFFFC07F}};

    // Reset held with lit inputs
    #1 reset_n = 1'b0;
    seg_in = 28'hFFFFFFF; brightness = 2'd3; blink_mask = '0;
    chk_on = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("reset_hex", 32'(hex_out), 32'h0FFFFFFF);
    check("reset_ft", 32'(frame_tick), 32'd0);
    reset_n = 1'b1;
    for (int j = 1; j < FRAME; j++) begin
      tick();
      check("dark_before_fb", 32'(hex_out), 32'h0FFFFFFF);
      check("no_ft_before_fb", 32'(frame_tick), 32'd0);
    end
    tick();
    check("first_fb_at_frame", 32'(frame_tick), 32'd1);
    tick();
    check("first_lit", 32'(hex_out), 32'h0);

    // Steady-state vectors, one full frame after each load
    for (int v = 0; v < 5; v++) begin
      seg_in = vecs[v].seg; brightness = vecs[v].br; blink_mask = '0;
      wait_ft({vecs[v].name, "_load"});
      for (int j = 1; j <= FRAME; j++) begin
        tick();
        check(vecs[v].name, 32'(hex_out), 32'(vecs[v].exp_hex[(j - 1) / PRE]));
      end
    end

    // Mid-frame change is held off until the next boundary
    seg_in = 28'h000007F; brightness = 2'd3;
    wait_ft("tear_load");
    for (int i = 0; i < 3; i++) tick();
    seg_in = 28'h0003F80;
    n = 0;
    do begin
      tick();
      n++;
      check("tear_hold_old", 32'(hex_out), 32'h0FFFFF80);
    end while (frame_tick !== 1'b1 && n < FRAME + 4);
    check("tear_fb_seen", 32'(frame_tick), 32'd1);
    tick();
    check("tear_switch_new", 32'(hex_out), 32'h0FFFC07F);

    // Blink on digit 0 only
    seg_in = 28'hFFFFFFF; brightness = 2'd3; blink_mask = 4'b0001;
    wait_ft("blink_load");
    lit0 = 0; others_bad = 0;
    for (int j = 0; j < 4 * FRAME; j++) begin
      tick();
      if (hex_out[6:0] == 7'h00) lit0++;
      if (hex_out[27:7] != '0) others_bad++;
    end
    check("blink_d0_lit_cycles", 32'(lit0), 32'(2 * FRAME));
    check("blink_others_lit", 32'(others_bad), 32'd0);

    // Reset pulse mid-frame while lit
    blink_mask = '0;
    wait_ft("rst_load");
    for (int i = 0; i < 3; i++) tick();
    check("lit_before_reset", 32'(hex_out), 32'h0);
    reset_n = 1'b0;
    #1;
    check("async_reset_dark", 32'(hex_out), 32'h0FFFFFFF);
    check("async_reset_ft", 32'(frame_tick), 32'd0);
    tick();
    reset_n = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (frame_tick !== 1'b1 && n < FRAME + 4);
    check("fb_after_reset_cycles", 32'(n), 32'(FRAME));

    // Random traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      tick();
      if ($urandom_range(3) == 0) begin
        seg_in     = 28'($urandom);
        brightness = PB'($urandom);
        blink_mask = ND'($urandom);
      end
    end

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
